// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy obstacle datapath: FSM state encodings,
// screen dimensions and the gap LFSR feedback tap mask.
package flappy_pkg;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_SCROLL = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register
   // (bits 7, 5, 4 and 3), which gives a maximal-length 255-state sequence.
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/gap_lfsr.sv
// Free-running 8-bit Fibonacci LFSR that supplies the pseudo-random gap
// position. It advances on every clock, so it never sits at one value and,
// started from a nonzero seed, never reaches the all-zero lock-up state.
module gap_lfsr
   import flappy_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       Clk,
   input  logic       reset,
   output logic [7:0] lfsr
);

   // Shift left every cycle, feeding back the XOR of the tapped bits.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         lfsr <= SEED;
      end else begin
         lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle stream generator: scrolls the obstacle left edge across the screen,
// picks a new gap position on every wrap, counts cleared obstacles and freezes
// on a collision until acknowledged.
// Optional macro SPEEDUP_EN: when defined, the scroll step grows with Score.
module obstacle_scroller
   import flappy_pkg::*;
#(
   parameter int         X_START   = 640,
   parameter int         STEP      = 1,
   parameter int         Y_BASE    = 160,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic       Tick,
   input  logic       Lose,
   output logic [9:0] X_Edge,
   output logic [9:0] Y_Edge,
   output logic [3:0] Score,
   output logic       Passed,
   output logic       Q_Init,
   output logic       Q_Scroll,
   output logic       Q_Frozen
);

   localparam logic [9:0] X_LOAD = 10'(X_START);
   localparam logic [9:0] Y_LOAD = 10'(Y_BASE);

   state_t     state;
   state_t     state_next;
   logic [9:0] x_next;
   logic [9:0] y_next;
   logic [3:0] score_next;
   logic       passed_next;
   logic [9:0] step;
   logic [9:0] gap_y;
   logic [7:0] lfsr;
   logic       unused_lfsr_msb;

   gap_lfsr #(
      .SEED (LFSR_SEED)
   ) u_gap_lfsr (
      .Clk   (Clk),
      .reset (reset),
      .lfsr  (lfsr)
   );

   assign unused_lfsr_msb = lfsr[7];
   assign gap_y           = Y_LOAD + {3'd0, lfsr[6:0]};

   // Per-tick move distance; the wrap test uses the same value so the
   // subtraction below can never underflow.
`ifdef SPEEDUP_EN
   assign step = 10'(STEP) + {8'd0, Score[3:2]};
`else
   assign step = 10'(STEP);
`endif

   // State and every output register, including the one-hot state flags.
   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state    <= ST_INIT;
         X_Edge   <= X_LOAD;
         Y_Edge   <= Y_LOAD;
         Score    <= 4'd0;
         Passed   <= 1'b0;
         Q_Init   <= 1'b1;
         Q_Scroll <= 1'b0;
         Q_Frozen <= 1'b0;
      end else begin
         state    <= state_next;
         X_Edge   <= x_next;
         Y_Edge   <= y_next;
         Score    <= score_next;
         Passed   <= passed_next;
         Q_Init   <= (state_next == ST_INIT);
         Q_Scroll <= (state_next == ST_SCROLL);
         Q_Frozen <= (state_next == ST_FROZEN);
      end
   end

   // Next-state and datapath decisions; a collision beats a move in SCROLL.
   always_comb begin
      state_next  = state;
      x_next      = X_Edge;
      y_next      = Y_Edge;
      score_next  = Score;
      passed_next = 1'b0;
      case (state)
         ST_INIT: begin
            x_next = X_LOAD;
            if (Start) begin
               state_next = ST_SCROLL;
               y_next     = gap_y;
            end
         end
         ST_SCROLL: begin
            if (Lose) begin
               state_next = ST_FROZEN;
            end else if (Tick) begin
               if (X_Edge < step) begin
                  x_next      = X_LOAD;
                  y_next      = gap_y;
                  passed_next = 1'b1;
                  if (Score != 4'd15) begin
                     score_next = Score + 4'd1;
                  end
               end else begin
                  x_next = X_Edge - step;
               end
            end
         end
         ST_FROZEN: begin
            if (Ack) begin
               state_next = ST_INIT;
               x_next     = X_LOAD;
               score_next = 4'd0;
            end
         end
         default: begin
            state_next = ST_INIT;
            x_next     = X_LOAD;
            score_next = 4'd0;
         end
      endcase
   end

endmodule

// File: tb/tb_obstacle_scroller.sv
// Self-checking bench for obstacle_scroller with default parameters
// (X_START 640, STEP 1, Y_BASE 160, seed A5). Expected values come from a
// behavioural model: position/score arithmetic plus the LFSR value computed
// from the number of clock edges since reset.
module tb_obstacle_scroller;

   logic       Clk;
   logic       reset;
   logic       Start;
   logic       Ack;
   logic       Tick;
   logic       Lose;
   logic [9:0] X_Edge;
   logic [9:0] Y_Edge;
   logic [3:0] Score;
   logic       Passed;
   logic       Q_Init;
   logic       Q_Scroll;
   logic       Q_Frozen;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int kk       = 0;

   logic [9:0] x_exp;
   logic [9:0] y_exp;
   logic [3:0] score_exp;
   logic       passed_exp;

   obstacle_scroller dut (
      .Clk      (Clk),
      .reset    (reset),
      .Start    (Start),
      .Ack      (Ack),
      .Tick     (Tick),
      .Lose     (Lose),
      .X_Edge   (X_Edge),
      .Y_Edge   (Y_Edge),
      .Score    (Score),
      .Passed   (Passed),
      .Q_Init   (Q_Init),
      .Q_Scroll (Q_Scroll),
      .Q_Frozen (Q_Frozen)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Number of clock edges seen since reset was last released.
   always @(posedge Clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // LFSR contents n edges after reset: x^8+x^6+x^5+x^4+1, seed A5.
   function automatic logic [7:0] lfsr_at(input int n);
      logic [7:0] v;
      v = 8'hA5;
      for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      return v;
   endfunction

   function automatic logic [9:0] gap_at(input int n);
      logic [7:0] v;
      v = lfsr_at(n);
      return 10'd160 + {3'd0, v[6:0]};
   endfunction

   // Drive inputs at the falling edge, let one rising edge pass, return at
   // the next falling edge where outputs are sampled.
   task automatic drive_cycle(input logic s, input logic a, input logic t, input logic l);
      Start = s; Ack = a; Tick = t; Lose = l;
      kk = cyc;
      @(posedge Clk);
      @(negedge Clk);
   endtask

   // Scroll-state model for a cycle without collision.
   task automatic model_scroll(input logic t, input int k);
      int st;
      passed_exp = 1'b0;
      if (t) begin
         st = 1;
`ifdef SPEEDUP_EN
         st = 1 + int'(score_exp) / 4;
`endif
         if (int'(x_exp) < st) begin
            x_exp      = 10'd640;
            y_exp      = gap_at(k);
            passed_exp = 1'b1;
            if (score_exp < 4'd15) score_exp = score_exp + 4'd1;
         end else begin
            x_exp = x_exp - 10'(st);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; Start = 0; Ack = 0; Tick = 0; Lose = 0;
      @(posedge Clk);
      @(negedge Clk);
      checks++;
      if ({X_Edge, Y_Edge, Score, Passed, Q_Init, Q_Scroll, Q_Frozen} !== {10'd640, 10'd160, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL reset_values got X=%0d Y=%0d S=%0d P=%b I/S/F=%b%b%b", X_Edge, Y_Edge, Score, Passed, Q_Init, Q_Scroll, Q_Frozen);
      end
      reset = 1'b0;
      x_exp = 10'd640; y_exp = 10'd160; score_exp = 4'd0; passed_exp = 1'b0;
      // INIT ignores Tick and Lose
      for (int i = 0; i < 3; i++) begin
         drive_cycle(0, 0, 1, 1);
         checks++;
         if (Q_Init !== 1'b1 || X_Edge !== 10'd640 || Y_Edge !== 10'd160) begin
            failures++;
            $display("[TB] FAIL init_hold got I=%b X=%0d Y=%0d exp I=1 X=640 Y=160", Q_Init, X_Edge, Y_Edge);
         end
      end
   endtask

   task automatic test_start;
      drive_cycle(1, 0, 0, 0);
      y_exp = gap_at(kk);
      checks++;
      if (Q_Scroll !== 1'b1 || Q_Init !== 1'b0 || X_Edge !== 10'd640 || Y_Edge !== y_exp) begin
         failures++;
         $display("[TB] FAIL start got S=%b I=%b X=%0d Y=%0d exp S=1 I=0 X=640 Y=%0d", Q_Scroll, Q_Init, X_Edge, Y_Edge, y_exp);
      end
      checks++;
      if (Y_Edge < 10'd160 || Y_Edge > 10'd287) begin
         failures++;
         $display("[TB] FAIL start_gap_range got Y=%0d exp 160..287", Y_Edge);
      end
      // Start still high: ignored while scrolling
      drive_cycle(1, 0, 0, 0);
      checks++;
      if (Q_Scroll !== 1'b1 || Y_Edge !== y_exp || X_Edge !== 10'd640) begin
         failures++;
         $display("[TB] FAIL start_ignored got S=%b Y=%0d X=%0d exp S=1 Y=%0d X=640", Q_Scroll, Y_Edge, X_Edge, y_exp);
      end
   endtask

   task automatic test_scroll_random;
      logic t;
      for (int i = 0; i < 2000; i++) begin
         t = ($urandom_range(0, 3) != 0);
         drive_cycle(0, 0, t, 0);
         model_scroll(t, kk);
         checks++;
         if (X_Edge !== x_exp || Y_Edge !== y_exp || Score !== score_exp || Passed !== passed_exp || Q_Scroll !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scroll_random i=%0d got X=%0d Y=%0d S=%0d P=%b Q=%b exp X=%0d Y=%0d S=%0d P=%b Q=1", i, X_Edge, Y_Edge, Score, Passed, Q_Scroll, x_exp, y_exp, score_exp, passed_exp);
         end
      end
   endtask

   task automatic test_freeze;
      int n;
      n = 0;
      while (!(x_exp >= 10'd300 && x_exp < 10'd310) && n < 1500) begin
         drive_cycle(0, 0, 1, 0);
         model_scroll(1'b1, kk);
         n++;
      end
      checks++;
      if (n >= 1500 || X_Edge !== x_exp) begin
         failures++;
         $display("[TB] FAIL freeze_approach got X=%0d exp X=%0d steps=%0d", X_Edge, x_exp, n);
      end
      // Lose and Tick together: freeze wins, no move
      drive_cycle(0, 0, 1, 1);
      checks++;
      if (Q_Frozen !== 1'b1 || Q_Scroll !== 1'b0 || X_Edge !== x_exp || Passed !== 1'b0) begin
         failures++;
         $display("[TB] FAIL freeze_entry got F=%b S=%b X=%0d P=%b exp F=1 S=0 X=%0d P=0", Q_Frozen, Q_Scroll, X_Edge, Passed, x_exp);
      end
      for (int i = 0; i < 6; i++) begin
         drive_cycle(0, 0, 1, 1'($urandom_range(0, 1)));
         checks++;
         if (Q_Frozen !== 1'b1 || X_Edge !== x_exp || Y_Edge !== y_exp || Score !== score_exp) begin
            failures++;
            $display("[TB] FAIL freeze_hold got F=%b X=%0d Y=%0d S=%0d exp F=1 X=%0d Y=%0d S=%0d", Q_Frozen, X_Edge, Y_Edge, Score, x_exp, y_exp, score_exp);
         end
      end
   endtask

   task automatic test_ack;
      drive_cycle(0, 1, 0, 0);
      x_exp = 10'd640; score_exp = 4'd0;
      checks++;
      if (Q_Init !== 1'b1 || Q_Frozen !== 1'b0 || X_Edge !== 10'd640 || Score !== 4'd0 || Y_Edge !== y_exp) begin
         failures++;
         $display("[TB] FAIL ack got I=%b F=%b X=%0d S=%0d Y=%0d exp I=1 F=0 X=640 S=0 Y=%0d", Q_Init, Q_Frozen, X_Edge, Score, Y_Edge, y_exp);
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(0, 0, 1, 1'($urandom_range(0, 1)));
         checks++;
         if (Q_Init !== 1'b1 || X_Edge !== 10'd640 || Y_Edge !== y_exp) begin
            failures++;
            $display("[TB] FAIL ack_idle got I=%b X=%0d Y=%0d exp I=1 X=640 Y=%0d", Q_Init, X_Edge, Y_Edge, y_exp);
         end
      end
   endtask

   task automatic test_saturation;
      int wraps;
      int n;
      drive_cycle(1, 0, 0, 0);
      y_exp = gap_at(kk);
      wraps = 0;
      n = 0;
      while (wraps < 20 && n < 20000) begin
         drive_cycle(0, 0, 1, 0);
         model_scroll(1'b1, kk);
         if (passed_exp) wraps++;
         n++;
         checks++;
         if (X_Edge !== x_exp || Y_Edge !== y_exp || Score !== score_exp || Passed !== passed_exp) begin
            failures++;
            $display("[TB] FAIL saturation_step n=%0d got X=%0d Y=%0d S=%0d P=%b exp X=%0d Y=%0d S=%0d P=%b", n, X_Edge, Y_Edge, Score, Passed, x_exp, y_exp, score_exp, passed_exp);
         end
      end
      checks++;
      if (Score !== 4'd15 || wraps != 20) begin
         failures++;
         $display("[TB] FAIL saturation_final got S=%0d wraps=%0d exp S=15 wraps=20", Score, wraps);
      end
   endtask

   task automatic test_async_reset;
      int n;
      n = 0;
      while (!(x_exp >= 10'd200 && x_exp < 10'd210) && n < 1000) begin
         drive_cycle(0, 0, 1, 0);
         model_scroll(1'b1, kk);
         n++;
      end
      checks++;
      if (n >= 1000 || X_Edge !== x_exp || Q_Scroll !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_approach got X=%0d Q=%b exp X=%0d Q=1", X_Edge, Q_Scroll, x_exp);
      end
      Tick = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({X_Edge, Y_Edge, Score, Passed, Q_Init, Q_Scroll, Q_Frozen} !== {10'd640, 10'd160, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("[TB] FAIL async_reset got X=%0d Y=%0d S=%0d P=%b I/S/F=%b%b%b", X_Edge, Y_Edge, Score, Passed, Q_Init, Q_Scroll, Q_Frozen);
      end
      @(negedge Clk);
      reset = 1'b0;
      x_exp = 10'd640; score_exp = 4'd0;
      drive_cycle(1, 0, 0, 0);
      y_exp = gap_at(kk);
      checks++;
      if (Q_Scroll !== 1'b1 || Y_Edge !== y_exp || X_Edge !== 10'd640) begin
         failures++;
         $display("[TB] FAIL restart_after_reset got S=%b Y=%0d X=%0d exp S=1 Y=%0d X=640", Q_Scroll, Y_Edge, X_Edge, y_exp);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_scroll_random();
      test_freeze();
      test_ack();
      test_saturation();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Drives the obstacle stream consumed by obstacle_logic.
- Owns obstacle position `X_Edge` (left edge, scrolls right-to-left) and gap position `Y_Edge` (pseudo-random per obstacle).
- Counts obstacles cleared and freezes on `Lose` from obstacle_logic until `Ack`.
- Sits between the frame-tick generator and obstacle_logic/VGA renderer.

Parameters:
- X_START, 640: `X_Edge` load value at reset, restart and wrap; must be ≤ 1023.
- STEP, 1: pixels moved per `Tick`; must be ≥ 1.
- Y_BASE, 160: minimum `Y_Edge`; `Y_Edge` = Y_BASE + lfsr[6:0], range Y_BASE..Y_BASE+127.
- LFSR_SEED, 8'hA5: LFSR reset value; must be nonzero.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- Start  in  1  level; begins scrolling from INIT.
- Ack  in  1  level; leaves FROZEN.
- Tick  in  1  one-cycle move strobe (frame rate).
- Lose  in  1  collision flag from obstacle_logic.
- X_Edge  out  10  obstacle left edge, unsigned pixels.
- Y_Edge  out  10  gap top edge, unsigned pixels.
- Score  out  4  obstacles cleared, saturates at 15.
- Passed  out  1  one-cycle pulse on obstacle wrap.
- Q_Init, Q_Scroll, Q_Frozen  out  1 each  one-hot state outputs.

Behaviour:
- All outputs registered. Reset values:
  - `X_Edge` = X_START; `Y_Edge` = Y_BASE; `Score` = 0; `Passed` = 0.
  - `Q_Init` = 1; `Q_Scroll` = 0; `Q_Frozen` = 0; LFSR = LFSR_SEED.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Shifts every cycle in every state, so it never holds and never reaches 0.
- INIT:
  - `Tick` and `Lose` ignored; `X_Edge` held at X_START.
  - `Start` → SCROLL next cycle; on the same edge `Y_Edge` <= Y_BASE + lfsr[6:0].
- SCROLL (priority order within a cycle):
  1. `Lose` = 1 → FROZEN next cycle; no move that cycle even if `Tick` = 1.
  2. Otherwise, on `Tick`:
     - if `X_Edge` < step (wrap): `X_Edge` <= X_START, `Y_Edge` <= Y_BASE + lfsr[6:0], `Passed` = 1 for one cycle, `Score` +1 (held at 15 once saturated).
     - else `X_Edge` <= `X_Edge` − step.
  - `Start` ignored.
- FROZEN:
  - `X_Edge`, `Y_Edge`, `Score` held.
  - `Ack` → INIT next cycle; on the same edge `X_Edge` <= X_START and `Score` <= 0. `Y_Edge` holds until the next `Start`.
- Latency: `Tick` to updated `X_Edge` is 1 cycle. `Lose` to `Q_Frozen` is 1 cycle.
- Arithmetic: 10-bit unsigned; the subtract never underflows because of the wrap check.
- `reset` asserted mid-operation returns everything to reset values immediately.
- `Passed` is 0 in every cycle without a wrap.

Optional Feature:
- Macro SPEEDUP_EN.
- Defined: step = STEP + Score[3:2] (STEP..STEP+3). The wrap comparison uses the same step.
- Undefined: step = STEP always; `Score` still counts.

Decomposition:
- Package flappy_pkg holds:
  - state encodings ST_INIT / ST_SCROLL / ST_FROZEN;
  - screen constants SCREEN_W = 640, SCREEN_H = 480;
  - LFSR tap mask.
- One sub-module: gap_lfsr, 8-bit free-running LFSR with seed parameter and async reset.

Test Plan:
- Reset, then `Start` pulsed for 2 cycles → `Q_Scroll` = 1 one cycle later; `Y_Edge` in 160..287; `X_Edge` = 640.
- X_START = 4, STEP = 1, five `Tick`s in SCROLL → `X_Edge` goes 3, 2, 1, 0, 4; `Passed` pulses on the 5th tick; `Score` = 1.
- `Lose` and `Tick` high in the same cycle with `X_Edge` = 300 → `Q_Frozen` = 1, `X_Edge` stays 300; further `Tick`s do not move it.
- In FROZEN, `Ack` = 1 → `Q_Init` = 1, `X_Edge` = X_START, `Score` = 0; a later `Tick` with no `Start` does not move `X_Edge`.
- X_START = 0, 20 wraps → `Score` saturates at 15. With SPEEDUP_EN: at `Score` = 12, `X_Edge` = 100, one `Tick` → `X_Edge` = 96.
- Assert `reset` mid-SCROLL at `X_Edge` = 200 → outputs return to reset values in the same cycle, without waiting for a clock edge.
